// File: rtl/progmem_jtag_player.sv
// Plays a packed TMS/TDI pair stream fetched from program memory out as JTAG
// cycles, collecting the returned TDO bits into 32-bit words for the host.
module progmem_jtag_player #(
   parameter int ADDR_W  = 9,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_dout,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo,
   output logic [31:0]       tdo_word,
   output logic [5:0]        tdo_bits,
   output logic              tdo_valid
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_REQ,
      HDR_WAIT,
      LD_REQ,
      LD_WAIT,
      SH_LO,
      SH_HI,
      FIN
   } state_t;

   localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] remaining;
   logic [3:0]  pair_idx;
   logic [7:0]  phase;
   logic [31:0] shift_reg;
   logic [31:0] cap_word;
   logic [5:0]  cap_cnt;
   logic [31:0] cap_word_upd;
   logic [5:0]  cap_cnt_upd;
   logic        phase_end;
   logic        last_pair;
   logic        sh_hi_first;
   logic        hi_exit;

   assign phase_end   = (phase == PHASE_LAST);
   assign last_pair   = (remaining == 16'd1);
   assign sh_hi_first = (state == SH_HI) && (phase == 8'd0);
   assign hi_exit     = (state == SH_HI) && phase_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = HDR_REQ;
         HDR_REQ:  state_next = HDR_WAIT;
         HDR_WAIT: state_next = (rom_dout[15:0] == 16'd0) ? FIN : LD_REQ;
         LD_REQ:   state_next = LD_WAIT;
         LD_WAIT:  state_next = SH_LO;
         SH_LO:    if (phase_end) state_next = SH_HI;
         SH_HI: begin
            if (phase_end) begin
               if (last_pair)               state_next = FIN;
               else if (pair_idx == 4'd15)  state_next = LD_REQ;
               else                         state_next = SH_LO;
            end
         end
         FIN:      state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      rom_en = (state == HDR_REQ) || (state == LD_REQ);
      busy   = (state != IDLE) && (state != FIN);
      done   = (state == FIN);
   end

   // TDO is folded in on the first high cycle; the merged view lets the
   // exit cycle see that bit even when CLK_DIV is 1.
   always_comb begin
      cap_word_upd = cap_word;
      cap_cnt_upd  = cap_cnt;
      if (sh_hi_first) begin
         cap_word_upd[cap_cnt[4:0]] = tdo;
         cap_cnt_upd = cap_cnt + 6'd1;
      end
   end

   // tck comes from a flop so the pad never sees decode glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tck       <= 1'b0;
         phase     <= 8'd0;
         rom_addr  <= '0;
         remaining <= 16'd0;
         pair_idx  <= 4'd0;
         shift_reg <= 32'd0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
      end else begin
         tck <= (state_next == SH_HI);

         if (state_next != state)
            phase <= 8'd0;
         else if ((state == SH_LO) || (state == SH_HI))
            phase <= phase + 8'd1;
         else
            phase <= 8'd0;

         if ((state == IDLE) && start)
            rom_addr <= '0;
         else if ((state_next == LD_REQ) && (state != LD_REQ))
            rom_addr <= rom_addr + ADDR_W'(1);

         if (state == HDR_WAIT)
            remaining <= rom_dout[15:0];
         else if (hi_exit)
            remaining <= remaining - 16'd1;

         // The first pair of a fresh word is presented straight from the read data.
         if (state == LD_WAIT) begin
            pair_idx  <= 4'd0;
            tdi       <= rom_dout[0];
            tms       <= rom_dout[1];
            shift_reg <= {2'b00, rom_dout[31:2]};
         end else if (hi_exit && (state_next == SH_LO)) begin
            pair_idx  <= pair_idx + 4'd1;
            tdi       <= shift_reg[0];
            tms       <= shift_reg[1];
            shift_reg <= {2'b00, shift_reg[31:2]};
         end
      end
   end

   // A word is handed over when full or when the final pair closes it early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_word  <= 32'd0;
         cap_cnt   <= 6'd0;
         tdo_word  <= 32'd0;
         tdo_bits  <= 6'd0;
         tdo_valid <= 1'b0;
      end else begin
         tdo_valid <= 1'b0;
         if (hi_exit && ((cap_cnt_upd == 6'd32) || last_pair)) begin
            tdo_valid <= 1'b1;
            tdo_word  <= cap_word_upd;
            tdo_bits  <= cap_cnt_upd;
            cap_word  <= 32'd0;
            cap_cnt   <= 6'd0;
         end else begin
            cap_word  <= cap_word_upd;
            cap_cnt   <= cap_cnt_upd;
         end
      end
   end

endmodule
